// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Upstream operand feeder for an N x N systolic array. Each accepted beat is one
// k-slice: N elements of an A column and N elements of a B row. The feeder
// re-times those slices into diagonally skewed lane streams, so that lane i
// arrives i advance steps after lane 0. Once the last slice has been accepted,
// the feeder pushes N-1 bubble steps to drain the diagonal and then pulses
// o_tile_done for one cycle.
//
// The delay line moves only on cycles where the array controller strobes
// i_adv while a tile is feeding or flushing. Element data is carried through
// bit-for-bit, with no arithmetic applied.
//
// Build option (macro): SKEW_ZERO_FILL_EN
//   defined   : a bubble loads a=b=0, so a lane with en=0 drives all-zero data
//               and an idle or drained array sees +0.0 on its buses.
//   undefined : a bubble clears only en, and each stage keeps its previous
//               a/b data. This reduces toggling on the wide data buses.
//   en_skew_out timing is the same in both builds.
//
// Parameters
//   DWIDTH : element width in bits
//   N      : number of lanes (array dimension)
//   KMAX   : maximum number of slices per tile
//   KW     : slice-count width, $clog2(KMAX+1)
//
// Ports
//   i_clk          clock
//   i_rst          synchronous reset, active high
//   i_start        begin a tile (sampled in IDLE only)
//   i_k_len        number of slices in the tile, latched on start
//                  (values above KMAX saturate to KMAX)
//   i_adv          array step strobe; one skew shift per cycle high
//   i_in_valid     a slice is available on i_a_vec_in / i_b_vec_in
//   o_in_ready     the feeder consumes a slice this cycle if one is valid
//   i_a_vec_in     A slice; lane i = bits [i*DWIDTH +: DWIDTH]
//   i_b_vec_in     B slice; same packing as i_a_vec_in
//   o_a_skew_out   skewed A lanes (to PE row i a_in)
//   o_b_skew_out   skewed B lanes (to PE column i b_in)
//   o_en_skew_out  lane i currently carries valid data
//   o_busy         a tile is in progress
//   o_tile_done    one-cycle pulse at the end of a tile
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
    parameter int DWIDTH = 64,
    parameter int N      = 4,
    parameter int KMAX   = 256,
    parameter int KW     = $clog2(KMAX + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [KW-1:0]       i_k_len,
    input  logic                i_adv,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [N*DWIDTH-1:0] i_a_vec_in,
    input  logic [N*DWIDTH-1:0] i_b_vec_in,
    output logic [N*DWIDTH-1:0] o_a_skew_out,
    output logic [N*DWIDTH-1:0] o_b_skew_out,
    output logic [N-1:0]        o_en_skew_out,
    output logic                o_busy,
    output logic                o_tile_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [KW-1:0] KMAX_K = KW'(KMAX);
    // The DONE transition happens on the flush step that brings the count to N-1.
    localparam logic [KW-1:0] FLUSH_LAST = KW'((N > 1) ? (N - 2) : 0);

    state_t        r_state;
    logic [KW-1:0] r_k_len;
    logic [KW-1:0] r_beat_cnt;
    logic [KW-1:0] r_flush_cnt;
    logic          r_busy;
    logic          r_tile_done;

    logic          w_in_ready;
    logic          w_fire;
    logic          w_step;
    logic [KW-1:0] w_k_len_sat;

    // Handshake: a slice may be consumed only on an advance step while feeding.
    always_comb begin
        w_in_ready = (r_state == ST_FEED) && i_adv;
        w_fire     = w_in_ready && i_in_valid;
        // The skew line moves only while a tile is feeding or flushing.
        // An adv in IDLE or DONE is ignored.
        w_step     = i_adv && ((r_state == ST_FEED) || (r_state == ST_FLUSH));
        if (i_k_len > KMAX_K) begin
            w_k_len_sat = KMAX_K;
        end else begin
            w_k_len_sat = i_k_len;
        end
    end

    // Tile sequencing FSM with registered busy / tile_done outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_k_len     <= {KW{1'b0}};
            r_beat_cnt  <= {KW{1'b0}};
            r_flush_cnt <= {KW{1'b0}};
            r_busy      <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tile_done <= 1'b0;
                    if (i_start) begin
                        r_k_len     <= w_k_len_sat;
                        r_beat_cnt  <= {KW{1'b0}};
                        r_flush_cnt <= {KW{1'b0}};
                        r_busy      <= 1'b1;
                        if (w_k_len_sat == {KW{1'b0}}) begin
                            r_state     <= ST_DONE;
                            r_tile_done <= 1'b1;
                        end else begin
                            r_state <= ST_FEED;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_FEED: begin
                    if (w_fire) begin
                        r_beat_cnt <= r_beat_cnt + KW'(1);
                        if (r_beat_cnt == (r_k_len - KW'(1))) begin
                            // A single lane has no diagonal to drain.
                            if (N == 1) begin
                                r_state     <= ST_DONE;
                                r_tile_done <= 1'b1;
                            end else begin
                                r_state <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (i_adv) begin
                        r_flush_cnt <= r_flush_cnt + KW'(1);
                        if (r_flush_cnt == FLUSH_LAST) begin
                            r_state     <= ST_DONE;
                            r_tile_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_tile_done <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_tile_done <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Triangular delay line. Lane gi has gi+1 stages. Stage 0 takes the new
    // slice, or a bubble, on each step. The last stage drives the array.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [gi:0]              r_en;
        logic [(gi+1)*DWIDTH-1:0] r_a;
        logic [(gi+1)*DWIDTH-1:0] r_b;
        logic [gi:0]              w_en_nxt;
        logic [(gi+1)*DWIDTH-1:0] w_a_nxt;
        logic [(gi+1)*DWIDTH-1:0] w_b_nxt;

        // Values each stage of this lane takes on the next advance step.
        always_comb begin
            w_en_nxt    = r_en;
            w_a_nxt     = r_a;
            w_b_nxt     = r_b;
            w_en_nxt[0] = w_fire;
            if (w_fire) begin
                w_a_nxt[DWIDTH-1:0] = i_a_vec_in[gi*DWIDTH +: DWIDTH];
                w_b_nxt[DWIDTH-1:0] = i_b_vec_in[gi*DWIDTH +: DWIDTH];
            end else begin
`ifdef SKEW_ZERO_FILL_EN
                w_a_nxt[DWIDTH-1:0] = {DWIDTH{1'b0}};
                w_b_nxt[DWIDTH-1:0] = {DWIDTH{1'b0}};
`else
                w_a_nxt[DWIDTH-1:0] = r_a[DWIDTH-1:0];
                w_b_nxt[DWIDTH-1:0] = r_b[DWIDTH-1:0];
`endif
            end
            for (int j = 1; j <= gi; j++) begin
                w_en_nxt[j] = r_en[j-1];
                // Data moves forward only together with a valid entry.
                // A bubble either zeroes the stage or leaves its data as it was.
                if (r_en[j-1]) begin
                    w_a_nxt[j*DWIDTH +: DWIDTH] = r_a[(j-1)*DWIDTH +: DWIDTH];
                    w_b_nxt[j*DWIDTH +: DWIDTH] = r_b[(j-1)*DWIDTH +: DWIDTH];
                end else begin
`ifdef SKEW_ZERO_FILL_EN
                    w_a_nxt[j*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
                    w_b_nxt[j*DWIDTH +: DWIDTH] = {DWIDTH{1'b0}};
`else
                    w_a_nxt[j*DWIDTH +: DWIDTH] = r_a[j*DWIDTH +: DWIDTH];
                    w_b_nxt[j*DWIDTH +: DWIDTH] = r_b[j*DWIDTH +: DWIDTH];
`endif
                end
            end
        end

        // Stage registers. They shift only on advance steps and hold otherwise.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_en <= {(gi+1){1'b0}};
                r_a  <= {((gi+1)*DWIDTH){1'b0}};
                r_b  <= {((gi+1)*DWIDTH){1'b0}};
            end else if (w_step) begin
                r_en <= w_en_nxt;
                r_a  <= w_a_nxt;
                r_b  <= w_b_nxt;
            end else begin
                r_en <= r_en;
                r_a  <= r_a;
                r_b  <= r_b;
            end
        end

        assign o_en_skew_out[gi]                 = r_en[gi];
        assign o_a_skew_out[gi*DWIDTH +: DWIDTH] = r_a[gi*DWIDTH +: DWIDTH];
        assign o_b_skew_out[gi*DWIDTH +: DWIDTH] = r_b[gi*DWIDTH +: DWIDTH];
    end

    assign o_in_ready  = w_in_ready;
    assign o_busy      = r_busy;
    assign o_tile_done = r_tile_done;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
//
// Randomised directed bench for systolic_skew_feeder (N=4, DWIDTH=64).
//
// The reference model works at the level of steps rather than registers:
//   - Every advance step appends one entry {en, A slice, B slice} to a history.
//   - After m steps, lane i shows entry m-1-i.
//   - The tile phase is tracked as work remaining: slices still to be consumed,
//     then bubble steps still to be flushed.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

    localparam int DW   = 64;
    localparam int NL   = 4;
    localparam int KMAX = 256;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int VW   = NL * DW;

    localparam int P_IDLE  = 0;
    localparam int P_FEED  = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;

    localparam logic [DW-1:0] A0 = 64'h3FF0000000000000;
    localparam logic [DW-1:0] A1 = 64'h4000000000000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          adv;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] a_in;
    logic [VW-1:0] b_in;
    logic [VW-1:0] a_out;
    logic [VW-1:0] b_out;
    logic [NL-1:0] en_out;
    logic          busy;
    logic          tile_done;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DWIDTH(DW), .N(NL), .KMAX(KMAX)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_k_len      (k_len),
        .i_adv        (adv),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_a_vec_in   (a_in),
        .i_b_vec_in   (b_in),
        .o_a_skew_out (a_out),
        .o_b_skew_out (b_out),
        .o_en_skew_out(en_out),
        .o_busy       (busy),
        .o_tile_done  (tile_done)
    );

    typedef struct {
        bit            en;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } ent_t;

    ent_t          hist[$];
    int            m_phase = P_IDLE;
    int            m_left  = 0;
    int            m_flush = 0;
    bit            m_fire  = 1'b0;
    int            n_cmp   = 0;
    int            n_fail  = 0;
    logic [VW-1:0] cur_a;
    logic [VW-1:0] cur_b;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic new_slice();
        cur_a = rand_vec();
        cur_b = rand_vec();
    endtask

    // Expected outputs derived from the step history.
    task automatic check_outputs();
        logic [NL-1:0] een;
        logic [VW-1:0] ea;
        logic [VW-1:0] eb;
        int            idx;
        een = '0;
        ea  = '0;
        eb  = '0;
        for (int i = 0; i < NL; i++) begin
            idx = hist.size() - 1 - i;
            if (idx >= 0) een[i] = hist[idx].en;
`ifdef SKEW_ZERO_FILL_EN
            if (idx >= 0 && hist[idx].en) begin
                ea[i*DW +: DW] = hist[idx].a[i*DW +: DW];
                eb[i*DW +: DW] = hist[idx].b[i*DW +: DW];
            end
`else
            // A lane keeps showing the last valid element that reached it.
            for (int k = idx; k >= 0; k--) begin
                if (hist[k].en) begin
                    ea[i*DW +: DW] = hist[k].a[i*DW +: DW];
                    eb[i*DW +: DW] = hist[k].b[i*DW +: DW];
                    break;
                end
            end
`endif
        end
        chk("en_skew_out", VW'(en_out), VW'(een));
        chk("a_skew_out", a_out, ea);
        chk("b_skew_out", b_out, eb);
        chk("busy", VW'(busy), VW'(m_phase != P_IDLE));
        chk("tile_done", VW'(tile_done), VW'(m_phase == P_DONE));
    endtask

    // One clock cycle.
    //   negedge : check in_ready.
    //   posedge : advance the model with the inputs the DUT samples.
    //   +1      : check the registered outputs.
    task automatic tick();
        bit   stepping;
        ent_t e;
        @(negedge clk);
        chk("in_ready", VW'(in_ready), VW'((m_phase == P_FEED) && adv));
        @(posedge clk);
        m_fire = 1'b0;
        if (rst) begin
            hist.delete();
            m_phase = P_IDLE;
            m_left  = 0;
            m_flush = 0;
        end else begin
            stepping = adv && (m_phase == P_FEED || m_phase == P_FLUSH);
            m_fire   = (m_phase == P_FEED) && adv && in_valid;
            if (stepping) begin
                e.en = m_fire;
                e.a  = a_in;
                e.b  = b_in;
                hist.push_back(e);
            end
            case (m_phase)
                P_IDLE: if (start) begin
                    m_left  = (int'(k_len) > KMAX) ? KMAX : int'(k_len);
                    m_flush = NL - 1;
                    m_phase = (m_left == 0) ? P_DONE : P_FEED;
                end
                P_FEED: if (m_fire) begin
                    m_left--;
                    if (m_left == 0) m_phase = (NL == 1) ? P_DONE : P_FLUSH;
                end
                P_FLUSH: if (adv) begin
                    m_flush--;
                    if (m_flush == 0) m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
        #1;
        check_outputs();
    endtask

    // Run one tile to completion.
    //   adv_mode < 0     : adv toggles 1,0,1,...
    //   adv_mode >= 0    : adv is high with that percentage.
    //   basic            : use the fixed A0/A1 slices and run the directed checks.
    //   done_tick        : tile_done cycle counted from the start cycle (0 = cycle after start).
    task automatic run_tile(input int kl, input int adv_mode, input int val_pct,
                            input bit same_adv, input bit stray, input bit basic,
                            output int done_tick, output int fires);
        bit finished;
        finished  = 1'b0;
        done_tick = -1;
        fires     = 0;
        if (basic) begin
            cur_a = {NL{A0}};
            cur_b = rand_vec();
        end
        start    = 1'b1;
        k_len    = KW'(kl);
        adv      = same_adv;
        in_valid = 1'b0;
        a_in     = rand_vec();
        b_in     = rand_vec();
        tick();
        start = 1'b0;
        if (tile_done === 1'b1) done_tick = 0;
        if (m_phase == P_IDLE) finished = 1'b1;
        for (int c = 1; c < 6000 && !finished; c++) begin
            if (adv_mode < 0) adv = (c % 2) == 1;
            else              adv = $urandom_range(0, 99) < adv_mode;
            in_valid = $urandom_range(0, 99) < val_pct;
            a_in     = in_valid ? cur_a : rand_vec();
            b_in     = in_valid ? cur_b : rand_vec();
            if (stray && $urandom_range(0, 9) == 0) begin
                start = 1'b1;
                k_len = KW'($urandom_range(0, 40));
            end else begin
                start = 1'b0;
            end
            tick();
            if (m_fire) begin
                fires++;
                if (basic) cur_a = {NL{A1}};
                else       new_slice();
            end
            if (tile_done === 1'b1 && done_tick < 0) done_tick = c;
            if (basic) begin
                case (c)
                    1: begin
                        chk("basic_lane0_A0", VW'(a_out[DW-1:0]), VW'(A0));
                        chk("basic_en_c1", VW'(en_out), VW'(4'b0001));
                    end
                    2: begin
                        chk("basic_lane0_A1", VW'(a_out[DW-1:0]), VW'(A1));
                        chk("basic_en_c2", VW'(en_out), VW'(4'b0011));
                    end
                    4: chk("basic_lane3_A0", VW'(a_out[VW-1 -: DW]), VW'(A0));
                    5: begin
                        chk("basic_lane3_A1", VW'(a_out[VW-1 -: DW]), VW'(A1));
                        chk("basic_en_c5", VW'(en_out), VW'(4'b1000));
                    end
                    default: ;
                endcase
            end
            if (m_phase == P_IDLE) finished = 1'b1;
        end
        start = 1'b0;
        chk("tile_finished", VW'(finished), VW'(1'b1));
    endtask

    initial begin
        int            dt;
        int            nf;
        logic [NL-1:0] en_before;

        rst      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        adv      = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        new_slice();
        repeat (2) tick();
        chk("reset_en", VW'(en_out), VW'(0));
        chk("reset_a", a_out, VW'(0));
        chk("reset_busy", VW'(busy), VW'(0));
        rst = 1'b0;
        tick();

        // Basic skew, k_len=2. The start cycle also has adv=1, which must not shift.
        run_tile(2, 100, 100, 1'b1, 1'b0, 1'b1, dt, nf);
        chk("basic_done_latency", VW'(dt), VW'(2 + NL - 1));
        chk("basic_fires", VW'(nf), VW'(2));

        // k_len = 0: done on the cycle after start, and no lane moves.
        en_before = en_out;
        run_tile(0, 100, 100, 1'b1, 1'b0, 1'b0, dt, nf);
        chk("k0_done_latency", VW'(dt), VW'(0));
        chk("k0_no_shift", VW'(en_out), VW'(en_before));

        // Backpressure: adv toggles, and no slice may be lost.
        run_tile(5, -1, 100, 1'b0, 1'b0, 1'b0, dt, nf);
        chk("toggle_fires", VW'(nf), VW'(5));

        // Bubble insertion: in_valid drops on some feed steps.
        run_tile(6, 100, 60, 1'b0, 1'b0, 1'b0, dt, nf);
        chk("bubble_fires", VW'(nf), VW'(6));

        // Random tiles. Stray starts arrive while busy and must be ignored.
        for (int t = 0; t < 6; t++) begin
            int kl;
            kl = $urandom_range(1, 20);
            run_tile(kl, 70, 70, 1'($urandom_range(0, 1)), 1'b1, 1'b0, dt, nf);
            chk("random_fires", VW'(nf), VW'(kl));
        end

        // k_len above KMAX saturates to KMAX.
        run_tile(300, 100, 100, 1'b0, 1'b0, 1'b0, dt, nf);
        chk("sat_fires", VW'(nf), VW'(KMAX));

        // Reset held 3 cycles in the middle of FEED aborts the tile.
        start    = 1'b1;
        k_len    = KW'(6);
        adv      = 1'b0;
        in_valid = 1'b0;
        tick();
        start    = 1'b0;
        adv      = 1'b1;
        in_valid = 1'b1;
        a_in     = cur_a;
        b_in     = cur_b;
        repeat (3) begin
            tick();
            if (m_fire) begin
                new_slice();
                a_in = cur_a;
                b_in = cur_b;
            end
        end
        rst = 1'b1;
        repeat (3) tick();
        rst      = 1'b0;
        adv      = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("midrst_en", VW'(en_out), VW'(0));
        chk("midrst_a", a_out, VW'(0));
        chk("midrst_b", b_out, VW'(0));
        chk("midrst_busy", VW'(busy), VW'(0));
        chk("midrst_done", VW'(tile_done), VW'(0));

        // adv strobes in IDLE must not move the line.
        for (int c = 0; c < 5; c++) begin
            adv = 1'($urandom_range(0, 1));
            tick();
        end

        // One more tile after the aborted one.
        run_tile(3, 80, 80, 1'b0, 1'b1, 1'b0, dt, nf);
        chk("post_rst_fires", VW'(nf), VW'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
